// File: rtl/bcd_scan_counter.sv
// ============================================================================
// Module      : bcd_scan_counter
// Description : DIGITS-wide BCD up/down counter with a time-multiplexed digit
//               scanner that feeds a seven-segment decoder (bcd + active-low an).
//               Optional macro LEADING_ZERO_BLANK_EN blanks leading-zero slots.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_scan_counter #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [3:0]            bcd,
    output logic [DIGITS-1:0]     an
);

    localparam int c_PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] count_q, count_d;
    logic                wrap_q, wrap_d;
    logic [c_PRE_W-1:0]  pre_q, pre_d;
    logic [c_IDX_W-1:0]  idx_q, idx_d;

    logic                w_carry;
    logic [3:0]          w_nib;
    logic [3:0]          w_sel;
    logic                w_blank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            pre_q   <= '0;
            idx_q   <= '0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
        end
    end

    // Ripple carry/borrow: a digit only changes while the carry from below is set.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        w_carry = 1'b1;
        w_nib   = '0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            for (int i = 0; i < DIGITS; i++) begin
                w_nib = load_val[4*i +: 4];
                count_d[4*i +: 4] = (w_nib > 4'd9) ? 4'd0 : w_nib;
            end
        end else if (en) begin
            for (int i = 0; i < DIGITS; i++) begin
                w_nib = count_q[4*i +: 4];
                if (w_carry) begin
                    if (up) begin
                        if (w_nib >= 4'd9) begin
                            count_d[4*i +: 4] = 4'd0;
                        end else begin
                            count_d[4*i +: 4] = w_nib + 4'd1;
                            w_carry = 1'b0;
                        end
                    end else begin
                        if (w_nib == 4'd0) begin
                            count_d[4*i +: 4] = 4'd9;
                        end else begin
                            count_d[4*i +: 4] = w_nib - 4'd1;
                            w_carry = 1'b0;
                        end
                    end
                end
            end
            wrap_d = w_carry;
        end
    end

    always_comb begin
        pre_d = pre_q + c_PRE_W'(1);
        idx_d = idx_q;
        if (pre_q == c_PRE_W'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == c_IDX_W'(DIGITS - 1)) ? '0 : idx_q + c_IDX_W'(1);
        end
    end

    always_comb begin
        w_sel = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == c_IDX_W'(i)) begin
                w_sel = count_q[4*i +: 4];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic w_zero_above;

    // Walk down from the top digit; digit 0 is excluded so a zero count shows "0".
    always_comb begin
        w_zero_above = 1'b1;
        w_blank      = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero_above = w_zero_above & (count_q[4*i +: 4] == 4'd0);
            if ((idx_q == c_IDX_W'(i)) && w_zero_above) begin
                w_blank = 1'b1;
            end
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        an = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == c_IDX_W'(i)) begin
                an[i] = w_blank;
            end
        end
    end

    assign bcd   = w_blank ? 4'd0 : w_sel;
    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_scan_counter.sv
// ============================================================================
// Module      : tb_bcd_scan_counter
// Description : Self-checking bench for bcd_scan_counter (DIGITS=4, SCAN_DIV=3)
//               using a vector table, directed corner sequences and random steps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_scan_counter;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 3;
    localparam int MODV     = 10000;

    logic                clk;
    logic                rst_n;
    logic                en;
    logic                up;
    logic                load;
    logic [4*DIGITS-1:0] load_val;
    logic                clr;
    logic [4*DIGITS-1:0] count;
    logic                wrap;
    logic [3:0]          bcd;
    logic [DIGITS-1:0]   an;

    int n_cmp;
    int n_fail;

    // Reference state: count as a plain integer, cycles since reset release.
    int   m_val;
    logic m_wrap;
    int   m_cyc;

    bcd_scan_counter #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .clr      (clr),
        .count    (count),
        .wrap     (wrap),
        .bcd      (bcd),
        .an       (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pow10(input int n);
        int r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return r;
    endfunction

    function automatic int load_to_int(input logic [15:0] lv);
        int r = 0;
        int nib;
        for (int k = 0; k < DIGITS; k++) begin
            nib = int'(lv[4*k +: 4]);
            if (nib <= 9) r = r + nib * pow10(k);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int idx;
        int dig;
        bit blank;
        logic [DIGITS-1:0] exp_an;
        idx   = (m_cyc / SCAN_DIV) % DIGITS;
        dig   = (m_val / pow10(idx)) % 10;
`ifdef LEADING_ZERO_BLANK_EN
        blank = (idx != 0) && (m_val < pow10(idx));
`else
        blank = 1'b0;
`endif
        exp_an = blank ? '1 : ~(DIGITS'(1) << idx);
        check("count", 32'(count), 32'(to_bcd(m_val)));
        check("wrap",  32'(wrap),  32'(m_wrap));
        check("an",    32'(an),    32'(exp_an));
        check("bcd",   32'(bcd),   blank ? 32'd0 : 32'(dig));
    endtask

    task automatic cycle(input logic c, input logic l, input logic e, input logic u,
                         input logic [15:0] v);
        clr = c; load = l; en = e; up = u; load_val = v;
        @(posedge clk);
        m_wrap = 1'b0;
        if (c) begin
            m_val = 0;
        end else if (l) begin
            m_val = load_to_int(v);
        end else if (e) begin
            if (u) begin
                m_wrap = (m_val == MODV - 1);
                m_val  = (m_val + 1) % MODV;
            end else begin
                m_wrap = (m_val == 0);
                m_val  = (m_val + MODV - 1) % MODV;
            end
        end
        m_cyc++;
        #1;
        check_all();
        clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0;
    endtask

    typedef struct {
        logic        c, l, e, u;
        logic [15:0] lv;
        logic [15:0] exp_count;
        logic        exp_wrap;
    } vec_t;

    vec_t vecs[13];

    initial begin
        n_cmp = 0; n_fail = 0;
        m_val = 0; m_wrap = 1'b0; m_cyc = 0;
        rst_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; clr = 1'b0; load_val = '0;

        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h9998, 16'h9998, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h9999, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h9999, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h9998, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h5555, 16'h0000, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h12A5, 16'h1205, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0100, 16'h0100, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0099, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0099, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0};

        #12;
        check("reset_count", 32'(count), 32'h0);
        check("reset_an",    32'(an),    32'hE);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].c, vecs[i].l, vecs[i].e, vecs[i].u, vecs[i].lv);
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_wrap", i),  32'(wrap),   32'(vecs[i].exp_wrap));
        end

        // Asynchronous reset between edges while showing 0347.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0347);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(count), 32'h0);
        check("async_rst_wrap",  32'(wrap),  32'h0);
        check("async_rst_an",    32'(an),    32'hE);
        check("async_rst_bcd",   32'(bcd),   32'h0);
        m_val = 0; m_wrap = 1'b0; m_cyc = 0;
        #1 rst_n = 1'b1;

        // Scan sequence over a full rotation and a bit more.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h1234);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Leading-zero cases (blanked only when the macro is defined).
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0070);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Random traffic; occasional loads near the wrap points.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] lv;
            lv = 16'($urandom);
            if ($urandom_range(0, 3) == 0) lv = ($urandom_range(0, 1) == 1) ? 16'h9999 : 16'h0000;
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, lv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
Multi-digit BCD up/down counter with a time-multiplexed display scanner, placed directly upstream of the seven-segment decoder. Holds DIGITS decimal digits and steps by one on each enable pulse. Cycles through the digits and presents one BCD nibble plus an active-low digit-select (anode) vector per scan slot. The nibble output drives the decoder's bcd input; the anode vector drives the shared-segment display commons.

Parameters:
DIGITS, 4, number of BCD digits counted and scanned (min 1, max 8)
SCAN_DIV, 1000, clk cycles each digit stays selected (min 1; 1 = advance every cycle)

Ports:
clk  input  1  system clock, all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  count step request, sampled per cycle; one step per high cycle
up  input  1  direction: 1 = increment, 0 = decrement; sampled with en
load  input  1  synchronous parallel load of load_val
load_val  input  4*DIGITS  packed BCD load value, digit 0 in bits [3:0]
clr  input  1  synchronous clear to all zeros
count  output  4*DIGITS  packed BCD count, registered, digit 0 in bits [3:0]
wrap  output  1  one-cycle pulse on roll-over (up past all-9s) or roll-under (down past all-0s)
bcd  output  4  BCD nibble of the currently selected digit, to decoder
an  output  DIGITS  one-cold active-low digit select; bit i low selects digit i

Behaviour:
- Clock clk; reset rst_n is asynchronous, active-low.
- Reset values: count = 0, wrap = 0, scan index = 0, prescaler = 0, an = all ones except bit 0 low (e.g. 4'b1110), bcd = 4'h0.
- Reset asserted mid-operation clears all state immediately, independent of clk. Release is synchronous to the next rising edge. The first count step is taken on the first edge with en high after release.
- Count-update priority per cycle: clr > load > en. Lower-priority requests in the same cycle are dropped, not queued.
- clr: count = 0 next cycle; wrap = 0.
- load: count = load_val next cycle. Any load nibble > 9 is stored as 0 for that digit only; other digits load unchanged. wrap = 0.
- en with up=1: digit 0 increments. A digit at 9 becomes 0 and carries into the next digit (ripple within the same cycle). All digits at 9 -> all 0, wrap = 1 for exactly that cycle.
- en with up=0: digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit. All digits at 0 -> all 9, wrap = 1 for exactly that cycle.
- Latency: count and wrap are visible on the edge after the request cycle (1-cycle latency). wrap is 0 in every other cycle.
- en held high steps once per cycle, with no edge detection. Continuous en up from 9998 (DIGITS=4) gives 9999, 0000 (wrap=1), 0001.
- Scanner: the prescaler counts 0..SCAN_DIV-1 every cycle, independent of en/clr/load. At terminal count it returns to 0 and the scan index advances. Index DIGITS-1 wraps to 0.
- an is decoded from the registered scan index and only ever has one bit low. bcd = count digit[scan index], combinational from registers; it follows count changes in the same cycle count changes.
- Scan continues during clr/load. Those events affect only the data shown, not the scan timing.

Optional Feature:
LEADING_ZERO_BLANK_EN:
- Defined: while the selected digit is a leading zero, all an bits are driven high for that slot and bcd is 0. A leading zero is a zero digit where every more-significant digit is also zero. Digit 0 is never blanked, so a count of 0 shows a single "0".
- Scan timing is unchanged; blanked slots still consume SCAN_DIV cycles.
- Undefined: every digit is always displayed, including leading zeros.

Test Plan:
- Reset: assert rst_n=0 mid-count at 0x0347, between clock edges -> count=0, wrap=0, an=4'b1110, bcd=0 immediately, without waiting for a clk edge.
- Roll-over: load 0x9998, then en=1 up=1 for 3 cycles -> count 9999, 0000 with wrap=1 for one cycle, then 0001 with wrap=0.
- Roll-under: clr, then en=1 up=0 for 1 cycle -> count=0x9999, wrap=1 for one cycle. One more step -> 0x9998.
- Priority and invalid load: clr=1, load=1, en=1 in the same cycle -> count=0. Next, load_val=0x12A5 -> count=0x1205.
- Scan: SCAN_DIV=3, count=0x1234 -> an/bcd sequence 1110/4, 1101/3, 1011/2, 0111/1, each held 3 cycles, then repeats from 1110/4.
- LEADING_ZERO_BLANK_EN defined, count=0x0070 -> digit 0 shows 0, digit 1 shows 7, digits 2 and 3 slots have an=4'b1111. With count=0, only digit 0 is lit.
